// File: rtl/control_pkg.sv
// Shared definitions for the commit-side control-flow recovery sequencer:
// FSM state encoding, control-flow record bit positions and the packed record.
package control_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUpdate,
    StFlush,
    StRedirect,
    StDrain
  } state_e;

  // Bit positions inside the 14-bit control-flow record
  localparam int unsigned PREV_IDX_HI = 13;
  localparam int unsigned PREV_IDX_LO = 6;
  localparam int unsigned STATE_HI    = 5;
  localparam int unsigned STATE_LO    = 4;
  localparam int unsigned WRITE_BTB   = 3;
  localparam int unsigned TAKEN       = 2;
  localparam int unsigned MISPREDICT  = 1;
  localparam int unsigned MISDIRECT   = 0;

  typedef struct packed {
    logic [7:0] prev_index;
    logic [1:0] state;
    logic       write_btb;
    logic       taken;
    logic       mispredict;
    logic       misdirect;
  } control_flow_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter update (purely combinational).
module sat_counter2 (
  input  logic [1:0] cur_state,
  input  logic       up,
  output logic [1:0] next_state
);

  // Step towards 3 when up, towards 0 otherwise, holding at the rails
  always_comb begin
    next_state = cur_state;
    if (up) begin
      if (cur_state != 2'b11) next_state = cur_state + 2'd1;
    end else begin
      if (cur_state != 2'b00) next_state = cur_state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Commit-side sequencer for control-flow instructions at the ROB head.
// Retires non-control heads in zero cycles; for branches/jumps it issues
// predictor/BTB updates and, on mispredict/misdirect, runs flush ->
// register-status restore -> redirect -> drain while stalling the front end.
// Optional feature: define BRANCH_PERF_CNT_EN to add branchCount and
// mispredictCount (16-bit saturating) outputs.
module branch_recovery_ctrl
  import control_pkg::*;
#(
  parameter int unsigned WIDTH   = 31,
  parameter int unsigned CONTROL = 13,
  parameter int unsigned DRAIN   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             headValid,
  input  logic             headIsControl,
  input  logic [CONTROL:0] controlFlow,
  input  logic [WIDTH:0]   targetAddress,
  input  logic [WIDTH:0]   seqPC,
  input  logic [WIDTH:0]   regStatus,
  output logic             commitAck,
  output logic             predWrite,
  output logic [7:0]       predIndex,
  output logic [1:0]       predState,
  output logic             btbWrite,
  output logic [WIDTH:0]   btbTarget,
  output logic             flush,
  output logic             rstWrite,
  output logic [WIDTH:0]   rstSnapshot,
  output logic             redirect,
  output logic [WIDTH:0]   redirectPC,
  output logic             stall
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [15:0]      branchCount,
  output logic [15:0]      mispredictCount
`endif
);

  localparam logic [3:0] DrainLoad = 4'(DRAIN - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  control_flow_t cf_q, cf_d;
  logic [WIDTH:0] target_q, target_d;
  logic [WIDTH:0] seq_q, seq_d;
  logic [WIDTH:0] reg_status_q, reg_status_d;
  logic [1:0]    sat_next;

  sat_counter2 u_sat_counter2 (
    .cur_state  (cf_q.state),
    .up         (cf_q.taken),
    .next_state (sat_next)
  );

  // State, drain counter and head-entry latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cf_q         <= '0;
      target_q     <= '0;
      seq_q        <= '0;
      reg_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cf_q         <= cf_d;
      target_q     <= target_d;
      seq_q        <= seq_d;
      reg_status_q <= reg_status_d;
    end
  end

  // Next-state logic; head inputs are only sampled in idle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cf_d         = cf_q;
    target_d     = target_q;
    seq_d        = seq_q;
    reg_status_d = reg_status_q;
    unique case (state_q)
      StIdle: begin
        if (headValid && headIsControl) begin
          cf_d.prev_index = controlFlow[PREV_IDX_HI:PREV_IDX_LO];
          cf_d.state      = controlFlow[STATE_HI:STATE_LO];
          cf_d.write_btb  = controlFlow[WRITE_BTB];
          cf_d.taken      = controlFlow[TAKEN];
          cf_d.mispredict = controlFlow[MISPREDICT];
          cf_d.misdirect  = controlFlow[MISDIRECT];
          target_d        = targetAddress;
          seq_d           = seqPC;
          reg_status_d    = regStatus;
          state_d         = StUpdate;
        end
      end
      StUpdate: begin
        // Both error bits together still give one recovery pass
        state_d = (cf_q.mispredict || cf_q.misdirect) ? StFlush : StIdle;
      end
      StFlush: begin
        state_d = StRedirect;
      end
      StRedirect: begin
        cnt_d   = DrainLoad;
        state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs from state and latches; idle ack is the only Mealy term
  always_comb begin
    commitAck   = 1'b0;
    predWrite   = 1'b0;
    predIndex   = '0;
    predState   = '0;
    btbWrite    = 1'b0;
    btbTarget   = '0;
    flush       = 1'b0;
    rstWrite    = 1'b0;
    rstSnapshot = '0;
    redirect    = 1'b0;
    redirectPC  = '0;
    stall       = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        // Gate with reset so nothing pulses while reset is held
        commitAck = reset && headValid && !headIsControl;
      end
      StUpdate: begin
        predWrite = 1'b1;
        predIndex = cf_q.prev_index;
        predState = sat_next;
        btbWrite  = cf_q.write_btb;
        btbTarget = target_q;
        commitAck = !(cf_q.mispredict || cf_q.misdirect);
      end
      StFlush: begin
        flush       = 1'b1;
        rstWrite    = 1'b1;
        rstSnapshot = reg_status_q;
        commitAck   = 1'b1;
      end
      StRedirect: begin
        redirect   = 1'b1;
        redirectPC = cf_q.taken ? target_q : seq_q;
      end
      StDrain: begin
      end
      default: begin
      end
    endcase
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [15:0] branch_cnt_q, mispredict_cnt_q;

  // Saturating event counters for updates and recoveries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (state_q == StUpdate && branch_cnt_q != 16'hFFFF) begin
        branch_cnt_q <= branch_cnt_q + 16'd1;
      end
      if (state_q == StFlush && mispredict_cnt_q != 16'hFFFF) begin
        mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
      end
    end
  end

  assign branchCount     = branch_cnt_q;
  assign mispredictCount = mispredict_cnt_q;
`endif

endmodule
